// File: rtl/spi_receiver.sv
// -----------------------------------------------------------------------------
// spi_receiver
//   SPI mode-0 slave receiver. It oversamples sclk/mosi/cs with clock_in,
//   shifts mosi in MSB first on every detected sclk rising edge, and publishes
//   the completed frame when cs returns high.
//
// Parameters
//   DATA_WIDTH       width of the receive shift register and data_out
//
// Ports
//   clock_in         system clock, all logic on its rising edge
//   reset_n_in       asynchronous active-low reset
//   sclk_in          SPI serial clock (asynchronous)
//   mosi_in          SPI serial data (asynchronous)
//   cs_in            SPI chip select, active low (asynchronous)
//   data_out         last completed frame, right-aligned
//   data_length_out  number of sclk rising edges in that frame (saturates at 63)
//   valid_out        one-cycle pulse when data_out/data_length_out update
//   busy_out         high while a frame is being received
//   overrun_out      (only with SPI_RECEIVER_OVERRUN_EN) frame was longer than
//                    DATA_WIDTH bits; updated together with valid_out
//
// Optional feature macro: SPI_RECEIVER_OVERRUN_EN
// -----------------------------------------------------------------------------
module spi_receiver #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  sclk_in,
  input  logic                  mosi_in,
  input  logic                  cs_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [5:0]            data_length_out,
  output logic                  valid_out,
`ifdef SPI_RECEIVER_OVERRUN_EN
  output logic                  overrun_out,
`endif
  output logic                  busy_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                state, next_state;
  logic [2:0]            sclk_sync, mosi_sync, cs_sync;
  logic [1:0]            settle;
  logic                  armed;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [5:0]            bit_count;
  logic                  sclk_rise, cs_rise, cs_fall;
  logic                  shift_clear, shift_en;

  // Synchronizer stages: [0] and [1] form the 2-flop synchronizer, [2] is the
  // delayed copy used only for edge detection.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sclk_sync <= 3'b000;
      mosi_sync <= 3'b000;
      cs_sync   <= 3'b111;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk_in};
      mosi_sync <= {mosi_sync[1:0], mosi_in};
      cs_sync   <= {cs_sync[1:0], cs_in};
    end
  end

  // The cs synchronizer resets to "deselected", so releasing reset while the
  // master holds cs low would look like a falling edge. Frame starts are only
  // accepted after cs has genuinely been sampled high once the reset values
  // have been flushed out of the synchronizer.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && cs_sync[2]) armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = armed & ~cs_sync[1] & cs_sync[2];

  // Frame-control state register
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state  = state;
    shift_clear = 1'b0;
    shift_en    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          next_state  = RECEIVE;
          shift_clear = 1'b1;
        end
      end
      RECEIVE: begin
        // cs deassertion takes priority over a coincident sclk edge.
        if (cs_rise)        next_state = (bit_count != 6'd0) ? DONE : IDLE;
        else if (sclk_rise) shift_en   = 1'b1;
      end
      DONE: begin
        if (cs_fall) begin
          next_state  = RECEIVE;
          shift_clear = 1'b1;
        end else begin
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Receive shift register and saturating bit counter
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      shift_reg <= '0;
      bit_count <= 6'd0;
    end else if (shift_clear) begin
      shift_reg <= '0;
      bit_count <= 6'd0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_sync[1]};
      if (bit_count != 6'd63) bit_count <= bit_count + 6'd1;
    end
  end

  // Output registers: updated only in DONE, held otherwise
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      data_out        <= '0;
      data_length_out <= 6'd0;
      valid_out       <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      valid_out <= (state == DONE);
      busy_out  <= (next_state == RECEIVE);
      if (state == DONE) begin
        data_out        <= shift_reg;
        data_length_out <= bit_count;
      end
    end
  end

`ifdef SPI_RECEIVER_OVERRUN_EN
  localparam logic [6:0] DW7 = 7'(DATA_WIDTH);

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in)          overrun_out <= 1'b0;
    else if (state == DONE)   overrun_out <= ({1'b0, bit_count} > DW7);
  end
`endif

endmodule

// File: tb/tb_spi_receiver.sv
module tb_spi_receiver;
  localparam int DW = 16;

  logic          clock_in = 1'b0;
  logic          reset_n_in;
  logic          sclk_in, mosi_in, cs_in;
  logic [DW-1:0] data_out;
  logic [5:0]    data_length_out;
  logic          valid_out, busy_out;
`ifdef SPI_RECEIVER_OVERRUN_EN
  logic          overrun_out;
`endif

  spi_receiver #(.DATA_WIDTH(DW)) dut (
    .clock_in       (clock_in),
    .reset_n_in     (reset_n_in),
    .sclk_in        (sclk_in),
    .mosi_in        (mosi_in),
    .cs_in          (cs_in),
    .data_out       (data_out),
    .data_length_out(data_length_out),
    .valid_out      (valid_out),
`ifdef SPI_RECEIVER_OVERRUN_EN
    .overrun_out    (overrun_out),
`endif
    .busy_out       (busy_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic [15:0] data;
    logic [5:0]  len;
    logic        ovr;
  } exp_t;

  typedef struct {
    logic [79:0] bits;
    int          n;
    logic [15:0] data;
    logic [5:0]  len;
    logic        ovr;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   valid_seen = 0;
  int   frames_expected = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [15:0] last_data;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: the frame's bits as an n-bit number, MSB first; the receiver keeps
  // the low DW bits of that number and reports the bit count capped at 63.
  function automatic exp_t model(input logic [79:0] bits, input int n);
    exp_t        e;
    logic [79:0] v;
    v      = bits & ((80'd1 << n) - 80'd1);
    e.data = v[15:0];
    e.len  = (n > 63) ? 6'd63 : n[5:0];
    e.ovr  = (n > DW);
    return e;
  endfunction

  // Scoreboard: every valid pulse must match the oldest expected frame.
  always @(negedge clock_in) begin
    if (reset_n_in && valid_out) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual data=%0h len=%0d required none", data_out, data_length_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_data", 32'(data_out), 32'(mon_e.data));
        check("frame_len", 32'(data_length_out), 32'(mon_e.len));
`ifdef SPI_RECEIVER_OVERRUN_EN
        check("frame_overrun", 32'(overrun_out), 32'(mon_e.ovr));
`endif
      end
    end
  end

  // Caller must be at a negedge. Leaves cs high for hi_cycles afterwards.
  task automatic send_frame(input logic [79:0] bits, input int n, input int hi_cycles, input exp_t e);
    exp_q.push_back(e);
    frames_expected++;
    last_data = e.data;
    cs_in = 1'b0;
    repeat (6) @(negedge clock_in);
    for (int i = n - 1; i >= 0; i--) begin
      mosi_in = bits[i];
      repeat (5) @(negedge clock_in);
      sclk_in = 1'b1;
      repeat (5) @(negedge clock_in);
      if (i == n - 1) check("busy_in_frame", 32'(busy_out), 32'd1);
      sclk_in = 1'b0;
    end
    repeat (5) @(negedge clock_in);
    cs_in = 1'b1;
    repeat (hi_cycles) @(negedge clock_in);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen0;
    logic [95:0] r;
    exp_t        e;
    int          n;

    tbl[0] = '{80'h3F3C, 16, 16'h3F3C, 6'd16, 1'b0};
    tbl[1] = '{80'h16, 5, 16'h0016, 6'd5, 1'b0};
    tbl[2] = '{80'hABCDE, 20, 16'hBCDE, 6'd20, 1'b1};
    tbl[3] = '{80'h1, 1, 16'h0001, 6'd1, 1'b0};
    tbl[4] = '{80'h2A_0000_0000_0000_8001, 70, 16'h8001, 6'd63, 1'b1};
    tbl[5] = '{80'h0F0F0, 17, 16'hF0F0, 6'd17, 1'b1};

    reset_n_in = 1'b0;
    sclk_in = 1'b0;
    mosi_in = 1'b0;
    cs_in = 1'b1;
    repeat (3) @(negedge clock_in);
    check("reset_data", 32'(data_out), 32'd0);
    check("reset_len", 32'(data_length_out), 32'd0);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_busy", 32'(busy_out), 32'd0);
    reset_n_in = 1'b1;
    repeat (10) @(negedge clock_in);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      e = '{tbl[i].data, tbl[i].len, tbl[i].ovr};
      send_frame(tbl[i].bits, tbl[i].n, 15, e);
      check("busy_after_frame", 32'(busy_out), 32'd0);
    end

    // Latency from cs rising: valid visible just after the 4th posedge
    // counting the one that first samples cs high.
    e = '{16'h00A5, 6'd8, 1'b0};
    send_frame(80'hA5, 8, 0, e);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock_in);
      #1;
      check("latency_valid", 32'(valid_out), (k == 4) ? 32'd1 : 32'd0);
    end
    repeat (10) @(negedge clock_in);

    // cs low with no sclk: no frame, back to idle, outputs held
    seen0 = valid_seen;
    cs_in = 1'b0;
    repeat (20) @(negedge clock_in);
    cs_in = 1'b1;
    repeat (10) @(negedge clock_in);
    check("empty_frame_no_valid", 32'(valid_seen), 32'(seen0));
    check("empty_frame_idle", 32'(busy_out), 32'd0);
    check("data_held", 32'(data_out), 32'(last_data));

    // Reset mid-frame, then finish clocking the aborted frame: nothing reported
    seen0 = valid_seen;
    cs_in = 1'b0;
    repeat (6) @(negedge clock_in);
    for (int i = 15; i >= 8; i--) begin
      mosi_in = i[0];
      repeat (5) @(negedge clock_in);
      sclk_in = 1'b1;
      repeat (5) @(negedge clock_in);
      sclk_in = 1'b0;
    end
    reset_n_in = 1'b0;
    #1;
    check("midreset_data", 32'(data_out), 32'd0);
    check("midreset_len", 32'(data_length_out), 32'd0);
    repeat (3) @(negedge clock_in);
    check("midreset_busy", 32'(busy_out), 32'd0);
    check("midreset_valid", 32'(valid_out), 32'd0);
    reset_n_in = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      mosi_in = i[0];
      repeat (5) @(negedge clock_in);
      sclk_in = 1'b1;
      repeat (5) @(negedge clock_in);
      sclk_in = 1'b0;
    end
    repeat (5) @(negedge clock_in);
    cs_in = 1'b1;
    repeat (15) @(negedge clock_in);
    check("midreset_no_valid", 32'(valid_seen), 32'(seen0));
    e = '{16'h1234, 6'd16, 1'b0};
    send_frame(80'h1234, 16, 15, e);

    // Back-to-back frames with a one-cycle cs gap
    e = '{16'hAAAA, 6'd16, 1'b0};
    send_frame(80'hAAAA, 16, 1, e);
    e = '{16'h5555, 6'd16, 1'b0};
    send_frame(80'h5555, 16, 15, e);

    // Randomized frames against the reference model
    for (int t = 0; t < 25; t++) begin
      r = {$urandom, $urandom, $urandom};
      n = $urandom_range(1, 40);
      send_frame(r[79:0], n, (t == 24) ? 15 : $urandom_range(1, 12), model(r[79:0], n));
    end

    repeat (20) @(negedge clock_in);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("valid_count", 32'(valid_seen), 32'(frames_expected));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_receiver.md
SPI_RECEIVER -- requirements
Module: spi_receiver

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, width of the receive shift register and data_out.
REQ-002 clock_in  input  1  system clock; all logic on its rising edge.
REQ-003 reset_n_in  input  1  asynchronous, active-low reset.
REQ-004 sclk_in  input  1  SPI serial clock from the remote master, asynchronous to clock_in.
REQ-005 mosi_in  input  1  SPI serial data from the master, asynchronous.
REQ-006 cs_in  input  1  SPI chip select, active-low, asynchronous.
REQ-007 data_out  output  DATA_WIDTH  last completed frame, right-aligned.
REQ-008 data_length_out  output  6  number of sclk rising edges in the last completed frame.
REQ-009 valid_out  output  1  one-cycle pulse: data_out/data_length_out updated.
REQ-010 busy_out  output  1  high while a frame is in progress (state RECEIVE).

Function
REQ-011 sclk_in, mosi_in and cs_in shall each pass through a 2-flop synchronizer; edge detection shall compare stage 2 with a third delayed copy.
REQ-012 SPI mode 0: data is sampled on sclk rising edges, MSB first.
REQ-013 Supported sclk: period >= 8 clock_in cycles, high/low phases >= 4 cycles each.
REQ-014 FSM states: IDLE, RECEIVE, DONE.
REQ-015 IDLE: on detected cs falling edge -> clear shift register and bit counter, go to RECEIVE.
REQ-016 RECEIVE: on detected sclk rising edge -> shift register = {shift[DATA_WIDTH-2:0], synced mosi}; counter +1, saturating at 63.
REQ-017 RECEIVE: on detected cs rising edge -> DONE if counter > 0, else IDLE with no valid_out.
REQ-018 cs rising and sclk rising detected in the same cycle: the cs edge wins; the sclk edge is discarded.
REQ-019 DONE (one cycle): data_out <= shift register, data_length_out <= counter, valid_out = 1; next state IDLE.
REQ-020 A cs falling edge detected in DONE goes directly to RECEIVE with cleared shift register and counter; no frame is lost.
REQ-021 Frames longer than DATA_WIDTH retain the last DATA_WIDTH bits; data_length_out reports the true count, saturating at 63.
REQ-022 Frames shorter than DATA_WIDTH are right-aligned; the upper bits of data_out are zero.
REQ-023 data_out and data_length_out hold their value until the next DONE.
REQ-024 Latency: valid_out is high on the 4th clock_in rising edge after the first edge that samples cs_in high.
REQ-025 busy_out is registered and high exactly while in state RECEIVE.

Reset
REQ-026 While reset_n_in is low: state IDLE; synchronizers = 1 for cs and 0 for sclk/mosi; shift register, counter, data_out, data_length_out, valid_out and busy_out = 0.
REQ-027 Reset asserted mid-frame aborts the frame with no valid_out; after release, the first frame recognised starts with a new cs falling edge.

Configuration
REQ-028 Macro SPI_RECEIVER_OVERRUN_EN: when defined, add output overrun_out (1 bit), registered with valid_out, high iff the frame had more than DATA_WIDTH bits; reset 0.
REQ-029 Without SPI_RECEIVER_OVERRUN_EN, the overrun_out port and its logic are absent; all other behaviour is identical.

Verification
REQ-030 16-bit frame of 0x3F3C, sclk period 100 ns -> one valid_out pulse, data_out=0x3F3C, data_length_out=16, busy_out high for the frame.
REQ-031 5-bit frame 1,0,1,1,0 -> data_out=0x0016, data_length_out=5.
REQ-032 20-bit frame 0xABCDE -> data_out=0xBCDE, data_length_out=20, overrun_out=1 when the macro is defined.
REQ-033 cs low for 200 ns with no sclk, then high -> no valid_out, return to IDLE.
REQ-034 reset_n_in pulsed low after 8 bits of a 16-bit frame -> all outputs 0 and no valid_out; next full frame 0x1234 -> data_out=0x1234.
REQ-035 Two frames, 0xAAAA then 0x5555, with cs high for 1 clock_in cycle between them -> two valid_out pulses with the correct data in order.
